hashchecker: RTL and testbench

//   Stores a table of 128-bit NT (MD4 of UTF-16LE) target hashes, then answers membership queries.

---
 rtl/hashchecker_pkg.sv | 25 ++
 rtl/hashchecker_store.sv | 45 ++++
 rtl/hashchecker.sv | 94 +++++++++
 tb/tb_hashchecker.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/hashchecker_pkg.sv
// Shared types and sizing for the NT-hash target table and its search logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hashchecker_pkg;

    localparam int HASH_W = 128;
    localparam int DEPTH  = 16;

    // Count and search index must be able to hold DEPTH itself (full table / past-the-end).
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int ADDR_W = $clog2(DEPTH);

    typedef logic [HASH_W-1:0] hash_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/hashchecker_store.sv
// Target-hash table: append-only register array with a live entry count and indexed read.
// Latency: write lands on the clock edge of the request; read port is combinational.
// Backpressure: none; writes to a full table are dropped and the count saturates.
module hash_store
    import hashchecker_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  wr_en_i,
    input  hash_t wr_dat_i,
    input  addr_t rd_idx_i,
    output hash_t rd_dat_o,
    output cnt_t  count_o
);

    cnt_t  count_q;
    cnt_t  count_d;
    hash_t mem_q [DEPTH];
    logic  full;
    logic  wr_accept;

    assign full      = (count_q == DEPTH_CNT);
    assign wr_accept = wr_en_i && !full;
    assign count_d   = wr_accept ? count_q + cnt_t'(1) : count_q;

    // Entry count: only state that needs reset; it defines which entries are valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Table contents: written at the current count, never cleared (count gates validity).
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[count_q[ADDR_W-1:0]] <= wr_dat_i;
        end
    end

    assign rd_dat_o = mem_q[rd_idx_i];
    assign count_o  = count_q;

endmodule

// File: rtl/hashchecker.sv
// Stores up to DEPTH target hashes and answers "is this candidate a target?" by linear search.
// Latency: result k+1 cycles after the check edge (k = first matching index, or count on a miss).
// Backpressure: none; a new check edge restarts the search, stores are accepted at any time.
module hashchecker
    import hashchecker_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  newrdy,
    input  logic  checkrdy,
    input  hash_t hash,
    output logic  resultrdy,
    output logic  matchfound
);

    logic   new_q;
    logic   chk_q;
    logic   new_edge;
    logic   chk_edge;

    state_t state_q;
    hash_t  key_q;
    cnt_t   idx_q;
    logic   resultrdy_q;
    logic   matchfound_q;

    hash_t  rd_dat;
    cnt_t   count;

    // Requests are levels; act only on 0->1 against the previous cycle's value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            new_q <= 1'b0;
            chk_q <= 1'b0;
        end else begin
            new_q <= newrdy;
            chk_q <= checkrdy;
        end
    end

    assign new_edge = newrdy   && !new_q;
    assign chk_edge = checkrdy && !chk_q;

    hash_store u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (new_edge),
        .wr_dat_i (hash),
        .rd_idx_i (idx_q[ADDR_W-1:0]),
        .rd_dat_o (rd_dat),
        .count_o  (count)
    );

    // Search FSM: a check edge always (re)starts from index 0 with the new key.
    // The bound is the live count, so a store landing with the check edge is searched too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            key_q        <= '0;
            idx_q        <= '0;
            resultrdy_q  <= 1'b0;
            matchfound_q <= 1'b0;
        end else if (chk_edge) begin
            state_q      <= SEARCH;
            key_q        <= hash;
            idx_q        <= '0;
            resultrdy_q  <= 1'b0;
            matchfound_q <= 1'b0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (idx_q >= count) begin
                        matchfound_q <= 1'b0;
                        resultrdy_q  <= 1'b1;
                        state_q      <= DONE;
                    end else if (rd_dat == key_q) begin
                        matchfound_q <= 1'b1;
                        resultrdy_q  <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        idx_q <= idx_q + cnt_t'(1);
                    end
                end
                default: begin
                    // IDLE waits for a check edge; DONE holds the result until one arrives.
                end
            endcase
        end
    end

    assign resultrdy  = resultrdy_q;
    assign matchfound = matchfound_q;

endmodule

// File: tb/tb_hashchecker.sv
module tb_hashchecker;
    import hashchecker_pkg::*;

    logic  clk      = 1'b0;
    logic  rst_n    = 1'b0;
    logic  newrdy   = 1'b0;
    logic  checkrdy = 1'b0;
    hash_t hash     = '0;
    logic  resultrdy;
    logic  matchfound;

    int tests = 0;
    int fails = 0;

    // Reference model: the list of accepted targets, in store order.
    hash_t mtab[$];

    localparam hash_t H0 = 128'h0CB6948805F797BF2A82807973B89537;
    localparam hash_t H1 = 128'h7454070F0339BBC993CB08EAF741513A;
    localparam hash_t H2 = 128'h61FB34469B9989B01BE4E8630C52EED6;
    localparam hash_t H3 = 128'h7CE21F17C0AEE7FB9CEBA532D0546AD6;

    hashchecker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .newrdy     (newrdy),
        .checkrdy   (checkrdy),
        .hash       (hash),
        .resultrdy  (resultrdy),
        .matchfound (matchfound)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic hash_t rnd_hash();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Spec-level answer: first matching index decides found/latency; a miss scans all entries.
    task automatic model_lookup(input hash_t k, output logic found, output int lat);
        found = 1'b0;
        lat   = mtab.size() + 1;
        foreach (mtab[i]) begin
            if (!found && mtab[i] == k) begin
                found = 1'b1;
                lat   = i + 1;
            end
        end
    endtask

    task automatic do_store(input hash_t h, input int hold);
        @(negedge clk);
        hash   = h;
        newrdy = 1'b1;
        repeat (hold) @(negedge clk);
        newrdy = 1'b0;
        if (mtab.size() < DEPTH) mtab.push_back(h);
    endtask

    // Raise checkrdy (optionally with newrdy) and measure cycles from the edge to resultrdy.
    task automatic do_check(input string tag, input hash_t h, input int hold, input logic also_store);
        logic ef;
        int   el;
        int   lat;
        int   n;
        @(negedge clk);
        hash     = h;
        checkrdy = 1'b1;
        if (also_store) begin
            newrdy = 1'b1;
            if (mtab.size() < DEPTH) mtab.push_back(h);
        end
        model_lookup(h, ef, el);
        @(negedge clk);
        n      = 1;
        newrdy = 1'b0;
        if (n >= hold) checkrdy = 1'b0;
        chk({tag, "_clr"}, resultrdy, 0);
        lat = 0;
        while (!resultrdy && lat < 64) begin
            @(negedge clk);
            lat++;
            n++;
            if (n >= hold) checkrdy = 1'b0;
        end
        checkrdy = 1'b0;
        chk({tag, "_lat"}, lat, el);
        chk({tag, "_match"}, matchfound, ef);
        @(negedge clk);
        chk({tag, "_hold_rdy"}, resultrdy, 1);
        chk({tag, "_hold_match"}, matchfound, ef);
    endtask

    initial begin
        hash_t extra;
        hash_t k;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_resultrdy", resultrdy, 0);
        chk("rst_matchfound", matchfound, 0);
        rst_n = 1'b1;

        do_check("empty", rnd_hash(), 1, 1'b0);

        do_store(H0, 2);
        do_store(H1, 2);
        do_store(H2, 2);
        do_store(H2, 2);

        do_check("h0", H0, 2, 1'b0);
        do_check("h2", H2, 1, 1'b0);
        do_check("miss", H3, 1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(1, 0) == 1) k = mtab[$urandom_range(mtab.size() - 1, 0)];
            else                           k = rnd_hash();
            do_check("rand", k, $urandom_range(3, 1), 1'b0);
        end

        do_check("simul", rnd_hash(), 1, 1'b1);

        // Abandon a long miss search with a fresh check edge.
        @(negedge clk);
        hash     = rnd_hash();
        checkrdy = 1'b1;
        @(negedge clk);
        checkrdy = 1'b0;
        repeat (2) @(negedge clk);
        do_check("restart", H1, 1, 1'b0);

        while (mtab.size() < DEPTH) do_store(rnd_hash(), 1);
        extra = rnd_hash();
        do_store(extra, 1);
        do_check("full_drop", extra, 1, 1'b0);
        do_check("full_last", mtab[DEPTH-1], 1, 1'b0);

        // Asynchronous reset while a found result is being held.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_done_rdy", resultrdy, 0);
        chk("rst_done_match", matchfound, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mtab.delete();
        do_check("post_rst_empty", H0, 1, 1'b0);

        do_store(H0, 1);
        do_store(H1, 1);
        do_store(H2, 1);
        // Reset in the middle of a search: outputs drop and the table empties.
        @(negedge clk);
        hash     = H3;
        checkrdy = 1'b1;
        @(negedge clk);
        checkrdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_srch_rdy", resultrdy, 0);
        chk("rst_srch_match", matchfound, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mtab.delete();
        do_check("post_rst_srch", H1, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
